board_click_decoder: RTL and testbench

// - Input side of the board overlay: turns mouse position + left-button clicks into board occupancy.
// - Maps a click to one of 9 squares (square1..9, row-major; square3 = top-right) and records the current player's mark.
// - Alternates turns and detects win/draw.
// - Drives the per-square enables consumed by the draw_square* overlay stages.

---
 rtl/board_click_decoder_pkg.sv | 92 +++++++++
 rtl/board_click_decoder_win_detect.sv | 21 ++
 rtl/board_click_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_board_click_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_click_decoder_pkg.sv
// Shared definitions for the board click decoder.
// Holds the square geometry, the FSM state codes, the winner codes and the
// eight win-line masks. It also holds the helpers that map a mouse position
// to a board square.
package board_click_decoder_pkg;

    // Square geometry. Each range is inclusive. Columns 0 and 1 are
    // separated by a one-pixel grid line, and so are columns 1 and 2.
    // Rows are separated by a wider band.
    localparam logic [11:0] COL0_END = 12'd340;
    localparam logic [11:0] COL1_BEG = 12'd342;
    localparam logic [11:0] COL1_END = 12'd683;
    localparam logic [11:0] COL2_BEG = 12'd685;
    localparam logic [11:0] COL2_END = 12'd1023;
    localparam logic [11:0] ROW0_END = 12'd251;
    localparam logic [11:0] ROW1_BEG = 12'd258;
    localparam logic [11:0] ROW1_END = 12'd509;
    localparam logic [11:0] ROW2_BEG = 12'd516;
    localparam logic [11:0] ROW2_END = 12'd767;

    // Index returned when a click lands on a grid line or off the board.
    localparam logic [3:0] SQ_NONE = 4'd15;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_PRESSED = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;
    localparam logic [2:0] ST_CHECK   = 3'd5;
    localparam logic [2:0] ST_OVER    = 3'd6;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    // Bit n-1 stands for square n. Squares are numbered row-major, so
    // square 1 is bit 0 and square 3 (top-right) is bit 2.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'b001_010_100,   // anti-diagonal: squares 3,5,7
        9'b100_010_001,   // diagonal:      squares 1,5,9
        9'b100_100_100,   // right column
        9'b010_010_010,   // middle column
        9'b001_001_001,   // left column
        9'b111_000_000,   // bottom row
        9'b000_111_000,   // middle row
        9'b000_000_111    // top row
    };

    // Returns the slot (0..2) that v falls in on one axis, or 3 when v is
    // on a gap or past the last slot.
    function automatic logic [1:0] axis_slot(
        input logic [11:0] v,
        input logic [11:0] end0,
        input logic [11:0] beg1,
        input logic [11:0] end1,
        input logic [11:0] beg2,
        input logic [11:0] end2
    );
        logic [1:0] slot;
        slot = 2'd3;
        if (v <= end0) begin
            slot = 2'd0;
        end else if (v >= beg1 && v <= end1) begin
            slot = 2'd1;
        end else if (v >= beg2 && v <= end2) begin
            slot = 2'd2;
        end
        return slot;
    endfunction

    function automatic logic [3:0] square_index(
        input logic [11:0] x,
        input logic [11:0] y
    );
        logic [1:0] col;
        logic [1:0] row;
        logic [3:0] idx;
        col = axis_slot(x, COL0_END, COL1_BEG, COL1_END, COL2_BEG, COL2_END);
        row = axis_slot(y, ROW0_END, ROW1_BEG, ROW1_END, ROW2_BEG, ROW2_END);
        if (col == 2'd3 || row == 2'd3) begin
            idx = SQ_NONE;
        end else begin
            idx = ({2'b00, row} * 4'd3) + {2'b00, col};
        end
        return idx;
    endfunction

endpackage

// File: rtl/board_click_decoder_win_detect.sv
// board_win_detect: combinational three-in-a-row check for one player.
// Ports:
//   mask_i       in  9  squares held by the player (bit n-1 = square n)
//   line_found_o out 1  the player holds every square of at least one line
module board_win_detect
    import board_click_decoder_pkg::*;
(
    input  logic [8:0] mask_i,
    output logic       line_found_o
);

    always_comb begin
        line_found_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((mask_i & WIN_LINES[i]) == WIN_LINES[i]) begin
                line_found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_click_decoder.sv
// board_click_decoder: input side of the board overlay.
// Turns mouse position and left-button clicks into board occupancy. It also
// alternates the turns and detects a win or a draw.
// Ports:
//   pclk       in   1  pixel clock
//   rst        in   1  synchronous active-high reset
//   xpos/ypos  in  12  mouse position, held stable while the button is down
//   mouse_left in   1  left button level, asynchronous to pclk
//   start_en   in   1  game running; when low the board is cleared
//   choice_en  in   1  colour menu active; game input is frozen
//   square_x   out  9  squares holding X (bit n-1 = square n)
//   square_o   out  9  squares holding O
//   turn       out  1  0 = X to move, 1 = O to move
//   move_done  out  1  one-cycle pulse when a mark is written
//   illegal    out  1  one-cycle pulse for a click on a gap or an occupied square
//   game_over  out  1  level, high until start_en falls
//   winner     out  2  00 none, 01 X, 10 O, 11 draw
//
// state   | meaning
// IDLE    | game not active (stopped or menu open)
// ARMED   | waiting for a button press
// PRESSED | position latched, waiting for release
// DECODE  | mapping latched position to a square index
// COMMIT  | writing the mark or flagging the click illegal
// CHECK   | evaluating the board for win or draw
// OVER    | game finished, clicks ignored
module board_click_decoder
    import board_click_decoder_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    output logic [8:0]  square_x,
    output logic [8:0]  square_o,
    output logic        turn,
    output logic        move_done,
    output logic        illegal,
    output logic        game_over,
    output logic [1:0]  winner
);

    logic        ml_meta_q, ml_sync_q, ml_prev_q;
    logic [2:0]  state_q, state_d;
    logic [11:0] x_lat_q, x_lat_d;
    logic [11:0] y_lat_q, y_lat_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  sq_x_q, sq_x_d;
    logic [8:0]  sq_o_q, sq_o_d;
    logic        turn_q, turn_d;
    logic        move_done_q, move_done_d;
    logic        illegal_q, illegal_d;
    logic        game_over_q, game_over_d;
    winner_e     winner_q, winner_d;

    logic        press;
    logic        active;
    logic [8:0]  occupied;
    logic [8:0]  sq_onehot;
    logic        x_line, o_line;

    assign press     = ml_sync_q & ~ml_prev_q;
    assign active    = start_en & ~choice_en;
    assign occupied  = sq_x_q | sq_o_q;
    assign sq_onehot = (idx_q < 4'd9) ? (9'd1 << idx_q) : 9'd0;

    board_win_detect u_win_x (
        .mask_i       (sq_x_q),
        .line_found_o (x_line)
    );

    board_win_detect u_win_o (
        .mask_i       (sq_o_q),
        .line_found_o (o_line)
    );

    always_comb begin
        state_d     = state_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        idx_d       = idx_q;
        sq_x_d      = sq_x_q;
        sq_o_d      = sq_o_q;
        turn_d      = turn_q;
        move_done_d = 1'b0;
        illegal_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (press) begin
                    x_lat_d = xpos;
                    y_lat_d = ypos;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!ml_sync_q) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                idx_d   = square_index(x_lat_q, y_lat_q);
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (sq_onehot == 9'd0 || (sq_onehot & occupied) != 9'd0) begin
                    illegal_d = 1'b1;
                    state_d   = ST_ARMED;
                end else begin
                    if (turn_q) begin
                        sq_o_d = sq_o_q | sq_onehot;
                    end else begin
                        sq_x_d = sq_x_q | sq_onehot;
                    end
                    turn_d      = ~turn_q;
                    move_done_d = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Only one player can have just completed a line, so the
                // X-before-O order matters only for unreachable boards.
                if (x_line) begin
                    winner_d    = WIN_X;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else if (o_line) begin
                    winner_d    = WIN_O;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else if (&occupied) begin
                    winner_d    = WIN_DRAW;
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stopping the game wipes everything and wins over the menu freeze.
        if (!start_en) begin
            state_d     = ST_IDLE;
            sq_x_d      = 9'd0;
            sq_o_d      = 9'd0;
            turn_d      = 1'b0;
            move_done_d = 1'b0;
            illegal_d   = 1'b0;
            game_over_d = 1'b0;
            winner_d    = WIN_NONE;
        end else if (choice_en && state_q != ST_OVER) begin
            // Drop any in-flight click. A result found in CHECK this cycle
            // still has to land in OVER, or a finished game would be missed.
            sq_x_d      = sq_x_q;
            sq_o_d      = sq_o_q;
            turn_d      = turn_q;
            move_done_d = 1'b0;
            illegal_d   = 1'b0;
            if (!game_over_d) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            ml_meta_q   <= 1'b0;
            ml_sync_q   <= 1'b0;
            ml_prev_q   <= 1'b0;
            state_q     <= ST_IDLE;
            x_lat_q     <= 12'd0;
            y_lat_q     <= 12'd0;
            idx_q       <= SQ_NONE;
            sq_x_q      <= 9'd0;
            sq_o_q      <= 9'd0;
            turn_q      <= 1'b0;
            move_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            ml_meta_q   <= mouse_left;
            ml_sync_q   <= ml_meta_q;
            ml_prev_q   <= ml_sync_q;
            state_q     <= state_d;
            x_lat_q     <= x_lat_d;
            y_lat_q     <= y_lat_d;
            idx_q       <= idx_d;
            sq_x_q      <= sq_x_d;
            sq_o_q      <= sq_o_d;
            turn_q      <= turn_d;
            move_done_q <= move_done_d;
            illegal_q   <= illegal_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign square_x  = sq_x_q;
    assign square_o  = sq_o_q;
    assign turn      = turn_q;
    assign move_done = move_done_q;
    assign illegal   = illegal_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_board_click_decoder.sv
module tb_board_click_decoder;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        mouse_left, start_en, choice_en;
    logic [8:0]  square_x, square_o;
    logic        turn, move_done, illegal, game_over;
    logic [1:0]  winner;

    always #5 pclk = ~pclk;

    board_click_decoder dut (
        .pclk       (pclk),
        .rst        (rst),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .start_en   (start_en),
        .choice_en  (choice_en),
        .square_x   (square_x),
        .square_o   (square_o),
        .turn       (turn),
        .move_done  (move_done),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner)
    );

    typedef struct {
        bit         is_illegal;
        logic [8:0] sx;
        logic [8:0] so;
        logic       trn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference board model
    logic [8:0] m_x, m_o;
    logic       m_turn, m_over;
    logic [1:0] m_win;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_axis(input int v, input int e0, input int b1, input int e1,
                                  input int b2, input int e2);
        if (v >= 0 && v <= e0) return 0;
        if (v >= b1 && v <= e1) return 1;
        if (v >= b2 && v <= e2) return 2;
        return -1;
    endfunction

    function automatic bit m_has_line(input logic [8:0] b);
        int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int i = 0; i < 8; i++) begin
            if (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_x = '0; m_o = '0; m_turn = 1'b0; m_over = 1'b0; m_win = 2'b00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic check_board(input string tag);
        check({tag, "_square_x"}, 32'(square_x), 32'(m_x));
        check({tag, "_square_o"}, 32'(square_o), 32'(m_o));
        check({tag, "_turn"}, 32'(turn), 32'(m_turn));
        check({tag, "_game_over"}, 32'(game_over), 32'(m_over));
        check({tag, "_winner"}, 32'(winner), 32'(m_win));
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (!rst && (move_done || illegal)) begin
            check("pulse_exclusive", 32'(move_done & illegal), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 32'({move_done, illegal}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind_illegal", 32'(illegal), 32'(e.is_illegal));
                if (!e.is_illegal) begin
                    check("move_square_x", 32'(square_x), 32'(e.sx));
                    check("move_square_o", 32'(square_o), 32'(e.so));
                    check("move_turn", 32'(turn), 32'(e.trn));
                end
            end
        end
    end

    task automatic click(input int x, input int y, input int hold);
        int   c, r, idx;
        exp_t e;
        if (!m_over) begin
            c = m_axis(x, 340, 342, 683, 685, 1023);
            r = m_axis(y, 251, 258, 509, 516, 767);
            e.is_illegal = 1'b1;
            if (c >= 0 && r >= 0) begin
                idx = r * 3 + c;
                if (!m_x[idx] && !m_o[idx]) begin
                    e.is_illegal = 1'b0;
                    if (m_turn) m_o[idx] = 1'b1;
                    else        m_x[idx] = 1'b1;
                    m_turn = ~m_turn;
                    if (m_has_line(m_x))      begin m_win = 2'b01; m_over = 1'b1; end
                    else if (m_has_line(m_o)) begin m_win = 2'b10; m_over = 1'b1; end
                    else if (&(m_x | m_o))    begin m_win = 2'b11; m_over = 1'b1; end
                end
            end
            e.sx = m_x; e.so = m_o; e.trn = m_turn;
            sb_q.push_back(e);
        end
        xpos = 12'(x);
        ypos = 12'(y);
        tick(1);
        mouse_left = 1'b1;
        tick(hold);
        mouse_left = 1'b0;
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick(1);
        if (sb_q.size() != 0) begin
            check("pulse_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        tick(8);
        check_board("after_click");
    endtask

    task automatic new_game();
        start_en = 1'b0;
        tick(2);
        model_clear();
        check_board("cleared");
        start_en = 1'b1;
        tick(2);
    endtask

    int cx [3] = '{100, 500, 900};
    int cy [3] = '{100, 400, 650};

    task automatic play(input int idx);
        click(cx[idx % 3], cy[idx / 3], 5);
    endtask

    initial begin
        rst = 1'b1; start_en = 1'b0; choice_en = 1'b0; mouse_left = 1'b0;
        xpos = '0; ypos = '0;
        model_clear();
        tick(3);
        check_board("reset");
        check("reset_move_done", 32'(move_done), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        start_en = 1'b1;
        tick(2);

        // Repeat click on the same square
        click(100, 100, 6);
        click(100, 100, 6);

        // Clicks on grid gaps
        click(341, 100, 5);
        click(100, 255, 5);

        // Long hold gives exactly one mark
        new_game();
        click(400, 300, 500);
        check("hold_sq5", 32'(square_x[4]), 32'd1);

        // Reset in the middle of a game
        click(900, 100, 5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_clear();
        check_board("mid_reset");
        tick(2);
        click(800, 100, 5);
        check("after_reset_sq3", 32'(square_x), 32'h004);

        // Range boundaries
        new_game();
        click(340, 251, 5);
        click(342, 258, 5);
        click(684, 100, 5);
        click(1023, 767, 5);
        click(683, 509, 5);
        click(685, 516, 5);
        click(1024, 100, 5);
        click(100, 768, 5);
        click(0, 0, 5);
        click(683, 0, 5);

        // X completes the top row
        new_game();
        play(0); play(3); play(1); play(4); play(2);
        check("xwin_winner", 32'(winner), 32'd1);
        check("xwin_over", 32'(game_over), 32'd1);
        click(900, 650, 5);
        click(500, 650, 5);
        new_game();

        // Full board with no line
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8);
        check("draw_winner", 32'(winner), 32'd3);

        // Menu opened between press and release discards the click
        new_game();
        play(0);
        xpos = 12'd900; ypos = 12'd650;
        tick(1);
        mouse_left = 1'b1;
        tick(5);
        choice_en = 1'b1;
        tick(2);
        mouse_left = 1'b0;
        tick(6);
        choice_en = 1'b0;
        tick(8);
        check_board("freeze");
        play(8);
        check("resume_sq9", 32'(square_o[8]), 32'd1);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
